// File: rtl/ev_drive_controller.sv
// Multi-channel traction drive controller: precharge power-up sequencing,
// slew-limited per-motor speed ramps with thermal derate/trip, and PWM outputs.
module ev_drive_controller #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 4,
  parameter int PWM_W         = 8,
  parameter int TEMP_W        = 8,
  parameter int RAMP_DIV      = 4,
  parameter int RAMP_STEP     = 8,
  parameter int PRECHARGE_CYC = 16,
  parameter int TEMP_HOT      = 100,
  parameter int TEMP_COOL     = 90,
  parameter int TEMP_TRIP     = 120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     power_req,
  input  logic                     cmd_valid,
  input  logic [NUM_CH*DATA_W-1:0] accel,
  input  logic [NUM_CH*DATA_W-1:0] brake,
  input  logic [NUM_CH*TEMP_W-1:0] temp_in,
  input  logic                     fault_clr,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*PWM_W-1:0]  speed_out,
  output logic [NUM_CH-1:0]        overheat,
  output logic [2:0]               state,
  output logic                     ready
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PRECHARGE = 3'd1,
    S_RUN       = 3'd2,
    S_DERATE    = 3'd3,
    S_STOP      = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam int SUM_W  = PWM_W + 1;
  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PC_W   = (PRECHARGE_CYC > 1) ? $clog2(PRECHARGE_CYC) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(RAMP_DIV - 1);
  localparam logic [PC_W-1:0]   PC_LAST    = PC_W'(PRECHARGE_CYC - 1);
  localparam logic [SUM_W-1:0]  STEP_UP    = SUM_W'(RAMP_STEP);
  localparam logic [SUM_W-1:0]  STEP_DN    = SUM_W'(2 * RAMP_STEP);
  localparam logic [PWM_W-1:0]  STEP_DN_N  = PWM_W'(2 * RAMP_STEP);
  localparam logic [PWM_W-1:0]  DERATE_CAP = PWM_W'(1) << (PWM_W - 1);
  localparam logic [TEMP_W-1:0] HOT_T      = TEMP_W'(TEMP_HOT);
  localparam logic [TEMP_W-1:0] COOL_T     = TEMP_W'(TEMP_COOL);
  localparam logic [TEMP_W-1:0] TRIP_T     = TEMP_W'(TEMP_TRIP);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_cnt_q, pc_cnt_d;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic                 tick;
  logic [PWM_W-1:0]     pwm_cnt_q;
  logic                 pwm_active;

  logic [PWM_W-1:0]     target_q   [NUM_CH];
  logic [PWM_W-1:0]     target_d   [NUM_CH];
  logic [PWM_W-1:0]     speed_q    [NUM_CH];
  logic [PWM_W-1:0]     speed_d    [NUM_CH];
  logic [PWM_W-1:0]     eff_target [NUM_CH];
  logic [SUM_W-1:0]     up_sum     [NUM_CH];
  logic [SUM_W-1:0]     dn_floor   [NUM_CH];

  logic [NUM_CH-1:0]    overheat_q, overheat_d;
  logic                 any_trip, all_below_hot, all_stopped;
  logic                 cmd_load, clear_targets;

  assign tick          = (tick_cnt_q == TICK_LAST);
  assign ready         = (state_q == S_RUN) || (state_q == S_DERATE);
  assign pwm_active    = (state_q == S_RUN) || (state_q == S_DERATE) || (state_q == S_STOP);
  assign cmd_load      = cmd_valid && ready;
  assign clear_targets = (state_d == S_OFF) || (state_d == S_STOP) || (state_d == S_FAULT);

  // Thermal evaluation; overheat holds between the cool and hot thresholds.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    any_trip      = 1'b0;
    all_below_hot = 1'b1;
    overheat_d    = overheat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (temp_in[i*TEMP_W +: TEMP_W] >= TRIP_T) any_trip = 1'b1;
      if (temp_in[i*TEMP_W +: TEMP_W] >= HOT_T) begin
        all_below_hot = 1'b0;
        overheat_d[i] = 1'b1;
      end else if (temp_in[i*TEMP_W +: TEMP_W] <= COOL_T) begin
        overheat_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    all_stopped = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (speed_q[i] != '0) all_stopped = 1'b0;
    end
  end

  // Next-state logic; the new overheat value is used so derate tracks the same edge.
  always_comb begin
    state_d  = state_q;
    pc_cnt_d = '0;
    if (any_trip && (state_q != S_FAULT)) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_FAULT:     if (fault_clr && all_below_hot) state_d = S_OFF;
        S_OFF:       if (power_req) state_d = S_PRECHARGE;
        S_PRECHARGE: begin
          if (!power_req)              state_d  = S_STOP;
          else if (pc_cnt_q == PC_LAST) state_d  = S_RUN;
          else                          pc_cnt_d = pc_cnt_q + 1'b1;
        end
        S_RUN: begin
          if (!power_req)      state_d = S_STOP;
          else if (|overheat_d) state_d = S_DERATE;
        end
        S_DERATE: begin
          if (!power_req)       state_d = S_STOP;
          else if (~|overheat_d) state_d = S_RUN;
        end
        S_STOP:      if (all_stopped) state_d = S_OFF;
        default:     state_d = S_OFF;
      endcase
    end
  end

  // Per-channel target capture and slew-limited ramp toward the effective target.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      target_d[i]   = target_q[i];
      speed_d[i]    = speed_q[i];
      eff_target[i] = target_q[i];

      case (state_q)
        S_STOP:   eff_target[i] = '0;
        S_DERATE: if (target_q[i] > DERATE_CAP) eff_target[i] = DERATE_CAP;
        default:  ;
      endcase

      if (clear_targets) begin
        target_d[i] = '0;
      end else if (cmd_load) begin
        target_d[i] = (accel[i*DATA_W +: DATA_W] > brake[i*DATA_W +: DATA_W])
                    ? (PWM_W'(accel[i*DATA_W +: DATA_W] - brake[i*DATA_W +: DATA_W])
                       << (PWM_W - DATA_W))
                    : '0;
      end

      // One extra bit keeps the step comparisons free of wrap-around.
      up_sum[i]   = {1'b0, speed_q[i]} + STEP_UP;
      dn_floor[i] = {1'b0, eff_target[i]} + STEP_DN;

      if (state_d == S_FAULT) begin
        speed_d[i] = '0;
      end else if (tick) begin
        if (speed_q[i] < eff_target[i]) begin
          speed_d[i] = (up_sum[i] >= {1'b0, eff_target[i]}) ? eff_target[i]
                                                           : up_sum[i][PWM_W-1:0];
        end else if (speed_q[i] > eff_target[i]) begin
          speed_d[i] = ({1'b0, speed_q[i]} >= dn_floor[i]) ? (speed_q[i] - STEP_DN_N)
                                                           : eff_target[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      pc_cnt_q   <= '0;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      overheat_q <= '0;
      pwm_out    <= '0;
      // NOTE: targets and speeds are ordinary flops, so each element is reset explicitly.
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= '0;
        speed_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pc_cnt_q   <= pc_cnt_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      pwm_cnt_q  <= pwm_active ? pwm_cnt_q + 1'b1 : '0;
      overheat_q <= overheat_d;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= target_d[i];
        speed_q[i]  <= speed_d[i];
        pwm_out[i]  <= (state_d != S_FAULT) && (pwm_cnt_q < speed_q[i]);
      end
    end
  end

  assign state    = state_q;
  assign overheat = overheat_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_speed_out
    assign speed_out[g*PWM_W +: PWM_W] = speed_q[g];
  end

endmodule

// File: tb/tb_ev_drive_controller.sv
// Scoreboard bench for ev_drive_controller: directed scenarios plus random traffic,
// each cycle predicted by a behavioural model and compared by a separate monitor.
module tb_ev_drive_controller;

  localparam int NUM_CH        = 2;
  localparam int DATA_W        = 4;
  localparam int PWM_W         = 8;
  localparam int TEMP_W        = 8;
  localparam int RAMP_DIV      = 4;
  localparam int RAMP_STEP     = 8;
  localparam int PRECHARGE_CYC = 16;
  localparam int TEMP_HOT      = 100;
  localparam int TEMP_COOL     = 90;
  localparam int TEMP_TRIP     = 120;
  localparam int AW            = NUM_CH * DATA_W;

  localparam int ST_OFF = 0, ST_PRE = 1, ST_RUN = 2, ST_DER = 3, ST_STOP = 4, ST_FAULT = 5;

  logic                     clk = 1'b0;
  logic                     rst_n, power_req, cmd_valid, fault_clr;
  logic [AW-1:0]            accel, brake;
  logic [NUM_CH*TEMP_W-1:0] temp_in;
  logic [NUM_CH-1:0]        pwm_out, overheat;
  logic [NUM_CH*PWM_W-1:0]  speed_out;
  logic [2:0]               state;
  logic                     ready;

  ev_drive_controller #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PWM_W(PWM_W), .TEMP_W(TEMP_W),
    .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP), .PRECHARGE_CYC(PRECHARGE_CYC),
    .TEMP_HOT(TEMP_HOT), .TEMP_COOL(TEMP_COOL), .TEMP_TRIP(TEMP_TRIP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .power_req(power_req), .cmd_valid(cmd_valid),
    .accel(accel), .brake(brake), .temp_in(temp_in), .fault_clr(fault_clr),
    .pwm_out(pwm_out), .speed_out(speed_out), .overheat(overheat),
    .state(state), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]              st;
    logic [NUM_CH*PWM_W-1:0] spd;
    logic [NUM_CH-1:0]       pwm;
    logic [NUM_CH-1:0]       ovh;
    logic                    rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   pwm_hi_cnt = 0;
  bit   running    = 1'b0;

  // Behavioural model state, kept as plain integers.
  int m_state, m_age, m_cycles, m_pwm_cnt;
  int m_target [NUM_CH];
  int m_speed  [NUM_CH];
  bit m_ovh    [NUM_CH];
  bit m_pwm    [NUM_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ST_OFF; m_age = 1; m_cycles = 0; m_pwm_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_target[i] = 0; m_speed[i] = 0; m_ovh[i] = 1'b0; m_pwm[i] = 1'b0;
    end
  endtask

  // Predicts the DUT registers after the coming clock edge from current inputs.
  task automatic model_step();
    int ns, t, eff, sp, a, b;
    bit trip, all_below, any_hot, all_stopped, tick;
    bit novh [NUM_CH];
    bit np   [NUM_CH];
    int nt   [NUM_CH];
    int nsp  [NUM_CH];
    if (!rst_n) begin
      model_reset();
      return;
    end
    trip = 0; all_below = 1; any_hot = 0; all_stopped = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      t = int'(temp_in[i*TEMP_W +: TEMP_W]);
      if (t >= TEMP_TRIP) trip = 1;
      if (t >= TEMP_HOT) all_below = 0;
      if (t >= TEMP_HOT)       novh[i] = 1;
      else if (t <= TEMP_COOL) novh[i] = 0;
      else                     novh[i] = m_ovh[i];
      if (novh[i]) any_hot = 1;
      if (m_speed[i] != 0) all_stopped = 0;
    end

    ns = m_state;
    if (trip && m_state != ST_FAULT) ns = ST_FAULT;
    else begin
      case (m_state)
        ST_FAULT: if (fault_clr && all_below) ns = ST_OFF;
        ST_OFF:   if (power_req) ns = ST_PRE;
        ST_PRE:   if (!power_req) ns = ST_STOP; else if (m_age == PRECHARGE_CYC) ns = ST_RUN;
        ST_RUN:   if (!power_req) ns = ST_STOP; else if (any_hot) ns = ST_DER;
        ST_DER:   if (!power_req) ns = ST_STOP; else if (!any_hot) ns = ST_RUN;
        ST_STOP:  if (all_stopped) ns = ST_OFF;
        default:  ns = ST_OFF;
      endcase
    end

    tick = ((m_cycles % RAMP_DIV) == RAMP_DIV - 1);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_state == ST_STOP)     eff = 0;
      else if (m_state == ST_DER) eff = (m_target[i] < (1 << (PWM_W-1))) ? m_target[i] : (1 << (PWM_W-1));
      else                        eff = m_target[i];
      sp = m_speed[i];
      if (ns == ST_FAULT) sp = 0;
      else if (tick) begin
        if (sp < eff)      sp = (sp + RAMP_STEP < eff) ? sp + RAMP_STEP : eff;
        else if (sp > eff) sp = (sp - 2*RAMP_STEP > eff) ? sp - 2*RAMP_STEP : eff;
      end
      nsp[i] = sp;
      np[i]  = (ns != ST_FAULT) && (m_pwm_cnt < m_speed[i]);
      a = int'(accel[i*DATA_W +: DATA_W]);
      b = int'(brake[i*DATA_W +: DATA_W]);
      if (ns == ST_OFF || ns == ST_STOP || ns == ST_FAULT) nt[i] = 0;
      else if (cmd_valid && (m_state == ST_RUN || m_state == ST_DER))
        nt[i] = (a > b) ? (a - b) * (1 << (PWM_W - DATA_W)) : 0;
      else nt[i] = m_target[i];
    end

    m_pwm_cnt = (m_state == ST_RUN || m_state == ST_DER || m_state == ST_STOP)
              ? (m_pwm_cnt + 1) % (1 << PWM_W) : 0;
    m_age     = (ns == m_state) ? m_age + 1 : 1;
    m_state   = ns;
    m_cycles++;
    for (int i = 0; i < NUM_CH; i++) begin
      m_target[i] = nt[i]; m_speed[i] = nsp[i]; m_ovh[i] = novh[i]; m_pwm[i] = np[i];
    end
  endtask

  function automatic exp_t build_exp();
    exp_t e;
    e.st  = 3'(m_state);
    e.rdy = (m_state == ST_RUN) || (m_state == ST_DER);
    for (int i = 0; i < NUM_CH; i++) begin
      e.spd[i*PWM_W +: PWM_W] = PWM_W'(m_speed[i]);
      e.pwm[i] = m_pwm[i];
      e.ovh[i] = m_ovh[i];
    end
    return e;
  endfunction

  // Called at a falling edge with inputs settled; returns at the next falling edge.
  task automatic tick_cycle();
    model_step();
    sb_q.push_back(build_exp());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick_cycle();
  endtask

  task automatic set_temp(input int ch, input int t);
    temp_in[ch*TEMP_W +: TEMP_W] = TEMP_W'(t);
  endtask

  task automatic issue_cmd(input int ch, input int a, input int b);
    accel[ch*DATA_W +: DATA_W] = DATA_W'(a);
    brake[ch*DATA_W +: DATA_W] = DATA_W'(b);
    cmd_valid = 1'b1;
    tick_cycle();
    cmd_valid = 1'b0;
  endtask

  function automatic int pick_temp();
    case ($urandom_range(0, 9))
      6:       return TEMP_COOL;
      7:       return $urandom_range(TEMP_COOL + 1, TEMP_HOT - 1);
      8:       return $urandom_range(TEMP_HOT, TEMP_TRIP - 1);
      9:       return $urandom_range(TEMP_TRIP, 140);
      default: return $urandom_range(20, TEMP_COOL - 1);
    endcase
  endfunction

  function automatic int spd(input int ch);
    return int'(speed_out[ch*PWM_W +: PWM_W]);
  endfunction

  // Monitor: compares every registered output against the predicted snapshot.
  initial begin : monitor
    exp_t e;
    wait (running);
    forever begin
      @(posedge clk);
      #1;
      if (!running) break;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue, expected a prediction at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("sb_state",    state,     e.st);
        check("sb_speed",    speed_out, e.spd);
        check("sb_pwm",      pwm_out,   e.pwm);
        check("sb_overheat", overheat,  e.ovh);
        check("sb_ready",    ready,     e.rdy);
      end
      if (pwm_out[0]) pwm_hi_cnt++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int h0;
    rst_n = 1'b0; power_req = 1'b0; cmd_valid = 1'b0; fault_clr = 1'b0;
    accel = '0; brake = '0;
    for (int i = 0; i < NUM_CH; i++) set_temp(i, 25);
    model_reset();
    @(negedge clk);
    running = 1'b1;
    run(3);
    check("reset_state", state, ST_OFF);
    check("reset_ready", ready, 0);
    check("reset_speed", speed_out, 0);
    rst_n = 1'b1;
    run(2);

    // Power-up through precharge; a command during precharge is ignored.
    power_req = 1'b1;
    run(1);
    check("precharge_entry", state, ST_PRE);
    run(5);
    issue_cmd(0, 15, 0);
    run(9);
    check("precharge_last", state, ST_PRE);
    check("precharge_not_ready", ready, 0);
    run(1);
    check("run_entry", state, ST_RUN);
    check("run_ready", ready, 1);
    run(8);
    check("precharge_cmd_ignored", spd(0), 0);

    // Ramp up, decelerate to zero, clamp at full scale.
    issue_cmd(0, 10, 2);
    run(80);
    check("ramp_ch0_0x80", spd(0), 'h80);
    check("ramp_ch1_idle", spd(1), 0);
    issue_cmd(0, 5, 5);
    run(40);
    check("decel_to_zero", spd(0), 0);
    issue_cmd(0, 15, 0);
    run(140);
    check("clamp_0xf0", spd(0), 'hF0);

    // Derate with hysteresis.
    set_temp(1, 100);
    run(1);
    check("derate_entry", state, ST_DER);
    check("overheat_ch1", overheat, 2'b10);
    run(60);
    check("derate_cap", spd(0), 'h80);
    set_temp(1, 95);
    run(10);
    check("derate_hold", state, ST_DER);
    set_temp(1, 90);
    run(1);
    check("derate_exit", state, ST_RUN);
    run(80);
    check("derate_recover", spd(0), 'hF0);

    // Thermal trip and clear.
    set_temp(0, 120);
    run(1);
    check("trip_state", state, ST_FAULT);
    check("trip_speed", speed_out, 0);
    run(1);
    check("trip_pwm", pwm_out, 0);
    set_temp(0, 110);
    fault_clr = 1'b1;
    run(5);
    check("fault_hold_hot", state, ST_FAULT);
    set_temp(0, 50);
    run(1);
    check("fault_clear", state, ST_OFF);
    fault_clr = 1'b0;

    // Re-power, duty check at 0x40, then stop.
    run(17);
    check("repower_run", state, ST_RUN);
    issue_cmd(0, 4, 0);
    run(50);
    check("speed_0x40", spd(0), 'h40);
    h0 = pwm_hi_cnt;
    run(256);
    check("pwm_duty_0x40", pwm_hi_cnt - h0, 64);
    power_req = 1'b0;
    run(1);
    check("stop_entry", state, ST_STOP);
    run(30);
    check("stop_to_off", state, ST_OFF);
    check("stop_speed_zero", speed_out, 0);

    // Asynchronous reset mid-ramp while derating.
    power_req = 1'b1;
    set_temp(1, 105);
    run(17);
    issue_cmd(0, 15, 0);
    run(30);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", state, ST_OFF);
    check("async_rst_speed", speed_out, 0);
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_overheat", overheat, 0);
    check("async_rst_ready", ready, 0);
    run(2);
    set_temp(1, 25);
    power_req = 1'b0;
    rst_n = 1'b1;
    run(3);

    // Randomised traffic against the model.
    power_req = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) power_req = ~power_req;
      cmd_valid = ($urandom_range(0, 3) == 0);
      accel     = AW'($urandom);
      brake     = AW'($urandom);
      fault_clr = ($urandom_range(0, 7) == 0);
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 39) == 0) set_temp(ch, pick_temp());
      rst_n = ($urandom_range(0, 999) != 0);
      tick_cycle();
    end
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    run(2);

    running = 1'b0;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ev_drive_controller.md
# ev_drive_controller

Multi-channel, parametrised traction drive controller for the EV control system. It sequences power-up through a precharge delay and converts per-channel accelerator/brake commands into slew-limited motor speeds. Speeds are derated on overheat and forced to zero on thermal trip. It drives one PWM output per motor and sits between the PLC/HMI command decode and the motor power stages.

## Interface
- NUM_CH, 2, number of motor channels (1..8)
- DATA_W, 4, accelerator/brake command width
- PWM_W, 8, speed/PWM resolution; must be >= DATA_W
- TEMP_W, 8, per-channel temperature width
- RAMP_DIV, 4, clock cycles per ramp tick (>= 1)
- RAMP_STEP, 8, maximum speed increase per tick; decrease limit is 2*RAMP_STEP
- PRECHARGE_CYC, 16, cycles spent in PRECHARGE
- TEMP_HOT, 100, overheat set threshold (>=)
- TEMP_COOL, 90, overheat clear threshold (<=); must be < TEMP_HOT
- TEMP_TRIP, 120, thermal trip threshold (>=); must be > TEMP_HOT
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- power_req  in  1  drive enable request (PLC OR HMI, combined upstream)
- cmd_valid  in  1  strobe to sample accel/brake
- accel  in  NUM_CH*DATA_W  per-channel accelerator; channel i at [i*DATA_W +: DATA_W]
- brake  in  NUM_CH*DATA_W  per-channel brake, same packing
- temp_in  in  NUM_CH*TEMP_W  per-channel motor temperature, unsigned
- fault_clr  in  1  clears FAULT
- pwm_out  out  NUM_CH  registered PWM per channel
- speed_out  out  NUM_CH*PWM_W  current ramped speed per channel
- overheat  out  NUM_CH  per-channel overheat flag, with hysteresis
- state  out  3  OFF=0, PRECHARGE=1, RUN=2, DERATE=3, STOP=4, FAULT=5
- ready  out  1  high in RUN or DERATE

## Operation
- **Reset:** state=OFF; all speeds, targets, pwm_out, overheat, tick and PWM counters are 0; ready=0.
- **Target computation.** Performed on a cmd_valid cycle while ready=1:
  - target[i] = (accel>brake) ? (accel-brake)<<(PWM_W-DATA_W) : 0, unsigned.
  - cmd_valid is ignored in all other states; targets are cleared to 0 on entry to OFF, STOP and FAULT.
- **Effective target.** Equal to target[i]; in DERATE it is min(target[i], 2^(PWM_W-1)); in STOP it is 0.
- **Ramp.**
  - The tick counter runs freely from reset and ticks when count==RAMP_DIV-1, then wraps to 0.
  - On each tick, speed moves toward the effective target by at most RAMP_STEP up or 2*RAMP_STEP down.
  - The ramp lands exactly on the target; no overshoot or wrap. Intermediate arithmetic is PWM_W+1 bits, saturating.
- **Overheat.** overheat[i] sets when temp_in[i]>=TEMP_HOT and clears when temp_in[i]<=TEMP_COOL; otherwise it holds.
- **FSM.** Evaluated every cycle, highest priority first:
  - Any state except FAULT, any temp_in>=TEMP_TRIP -> FAULT.
  - FAULT -> OFF only when fault_clr=1 and all temp_in<TEMP_HOT. Otherwise FAULT holds; power_req is ignored.
  - OFF -> PRECHARGE when power_req=1.
  - PRECHARGE -> STOP if power_req drops. After PRECHARGE_CYC cycles in PRECHARGE -> RUN.
  - RUN/DERATE -> STOP when power_req=0.
  - RUN -> DERATE when any overheat=1; DERATE -> RUN when all overheat=0.
  - STOP -> OFF when all speeds are 0. Re-asserting power_req in STOP does not abort the ramp-down.
- **FAULT.** Speeds are zeroed in the same cycle the transition is registered (no ramp). pwm_out is forced to 0.
- **PWM.**
  - One shared PWM_W-bit counter increments every clk in RUN, DERATE and STOP, wrapping at 2^PWM_W-1 -> 0. It is held at 0 in other states.
  - pwm_out[i] <= (counter < speed[i]). speed=0 gives constant low; speed=2^PWM_W-1 gives high for all but one count per period.

## Timing
- cmd_valid at edge N -> target updated at N+1; first speed change at the next tick after N+1.
- Temperature crossing at edge N -> overheat/state updated at N+1; derating takes effect from the next tick.
- Trip at edge N -> state=FAULT, speed_out=0 at N+1, pwm_out=0 at N+2 at the latest.
- pwm_out lags the counter/speed by one register stage.
- power_req rising in OFF -> PRECHARGE next cycle; ready asserts exactly PRECHARGE_CYC cycles later.
- Asserting rst_n mid-operation returns all outputs to reset values immediately; the design is asynchronous through all flops.

## Test plan
All scenarios use default parameters.
- Power-up: power_req=1 from OFF -> state 1 for 16 cycles, then state 2 with ready=1; a cmd_valid issued during PRECHARGE leaves target at 0.
- Ramp: accel=0xA, brake=0x2 on ch0 -> target 0x80; speed_out ch0 steps 8,16,...,128 once every 4 cycles, then holds at 0x80; ch1 stays 0.
- Decel and clamp:
  - From 0x80, set accel=brake=0x5 -> speed falls 16 per tick to 0 and never wraps.
  - accel=0xF, brake=0 -> ramps to 0xF0 exactly.
- Derate: hold 0xF0, then raise temp ch1 to 100 -> state 3; ch0 ramps down to 0x80. Lower the temp to 95 -> state stays 3. Lower it to 90 -> state 2; ch0 ramps back to 0xF0.
- Trip and clear: temp ch0=120 while running -> state 5 and speeds 0 the next cycle; fault_clr with temp=110 -> stays FAULT; temp=50 with fault_clr -> OFF.
- Stop and reset:
  - power_req=0 at speed 0x40 -> STOP, ramp to 0, then OFF.
  - rst_n pulsed mid-ramp -> all outputs 0, state OFF.
  - PWM duty check at speed 0x40 -> 64 high counts per 256-cycle period.
